// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the push-button debouncer
package key_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Level of an active-low key that is not being pressed
    localparam logic KEY_IDLE_LEVEL = 1'b1;

    // 20 ms at 50 MHz for the board, short value for simulation
    localparam int DEBOUNCE_HW  = 1_000_000;
    localparam int DEBOUNCE_SIM = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, stability counter and FSM for one key
module debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_n,
    output logic key_db_n,
    output logic key_press,
    output logic key_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value held when the next stable sample completes qualification
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    key_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic       db_q, db_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Next-state logic: two-flop synchronizer feeding the qualification FSM
    always_comb begin
        sync1_d   = key_raw_n;
        sync2_d   = sync1_q;
        state_d   = state_q;
        count_d   = count_q;
        db_d      = db_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                count_d = '0;
                if (!sync2_q) begin
                    state_d = PRESS_WAIT;
                    count_d = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (sync2_q) begin
                    // Bounce back high: restart qualification silently
                    state_d = RELEASED;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d = PRESSED;
                    count_d = '0;
                    db_d    = 1'b0;
                    press_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PRESSED: begin
                count_d = '0;
                if (sync2_q) begin
                    state_d = RELEASE_WAIT;
                    count_d = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d   = RELEASED;
                    count_d   = '0;
                    db_d      = KEY_IDLE_LEVEL;
                    release_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                count_d = '0;
                db_d    = KEY_IDLE_LEVEL;
            end
        endcase
    end

    // State and registered outputs; reset abandons any wait with no pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= KEY_IDLE_LEVEL;
            sync2_q   <= KEY_IDLE_LEVEL;
            state_q   <= RELEASED;
            count_q   <= '0;
            db_q      <= KEY_IDLE_LEVEL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            count_q   <= count_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_db_n    = db_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - N independent push-button debounce channels
module key_debouncer
    import key_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] key_db_n,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    // One fully independent channel per key; downstream applies any priority
    for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key_raw_n  (key_raw_n[k]),
            .key_db_n   (key_db_n[k]),
            .key_press  (key_press[k]),
            .key_release(key_release[k])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - scoreboard bench for key_debouncer with a run-length reference model
module tb_key_debouncer;
    import key_pkg::*;

    localparam int NK = 3;
    localparam int D  = DEBOUNCE_SIM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_raw_n = '1;
    logic [NK-1:0] key_db_n;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    key_debouncer #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw_n  (key_raw_n),
        .key_db_n   (key_db_n),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a key's accepted level flips once D consecutive
    // samples (seen two clocks after the pin) disagree with it.
    typedef struct packed {
        logic [NK-1:0] db;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } exp_t;

    exp_t          exp_q[$];
    logic [NK-1:0] m_d1 = '1, m_d2 = '1;
    logic [NK-1:0] m_level = '1;
    int            m_run[NK];

    initial begin
        logic [NK-1:0] smp;
        exp_t          e;
        for (int k = 0; k < NK; k++) m_run[k] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_d1 = '1; m_d2 = '1; m_level = '1;
                for (int k = 0; k < NK; k++) m_run[k] = 0;
            end else begin
                smp  = m_d2;
                m_d2 = m_d1;
                m_d1 = key_raw_n;
                e.press = '0;
                e.rel   = '0;
                for (int k = 0; k < NK; k++) begin
                    if (smp[k] != m_level[k]) begin
                        m_run[k]++;
                        if (m_run[k] == D) begin
                            m_level[k] = smp[k];
                            m_run[k]   = 0;
                            if (smp[k] == 1'b0) e.press[k] = 1'b1;
                            else                e.rel[k]   = 1'b1;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
                e.db = m_level;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares each cycle's outputs against the queued expectation
    int   press_cnt[NK];
    int   rel_cnt[NK];
    logic saw_101 = 1'b0;

    initial begin
        exp_t e;
        for (int k = 0; k < NK; k++) begin press_cnt[k] = 0; rel_cnt[k] = 0; end
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NK; k++) begin
                    if (key_press[k])   press_cnt[k]++;
                    if (key_release[k]) rel_cnt[k]++;
                end
                if (key_press == 3'b101) saw_101 = 1'b1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("key_db_n",    int'(key_db_n),    int'(e.db));
                    chk("key_press",   int'(key_press),   int'(e.press));
                    chk("key_release", int'(key_release), int'(e.rel));
                    chk("press_release_exclusive", int'(key_press & key_release), 0);
                end
            end
        end
    end

    task automatic step(input logic [NK-1:0] v);
        @(posedge clk);
        #1 key_raw_n = v;
    endtask

    task automatic hold(input int n);
        repeat (n) step(key_raw_n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_db_n",    int'(key_db_n),    3'b111);
        chk("reset_press",   int'(key_press),   0);
        chk("reset_release", int'(key_release), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("in_reset_press", int'(key_press), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        do_reset();
        hold(3);

        // Clean press on key 0
        step(3'b110);
        hold(10);
        chk("clean_press_k0", press_cnt[0], 1);
        chk("clean_press_k1", press_cnt[1], 0);
        chk("clean_press_k2", press_cnt[2], 0);

        // Hold then release key 0
        hold(20);
        step(3'b111);
        hold(10);
        chk("release_k0",      rel_cnt[0],   1);
        chk("no_repeat_k0",    press_cnt[0], 1);
        chk("release_level_k0", int'(key_db_n[0]), 1);

        // Bounce train on key 1, then hold low
        step(3'b101); step(3'b111); step(3'b101); step(3'b111); step(3'b101);
        hold(10);
        chk("bounce_press_k1", press_cnt[1], 1);
        step(3'b111);
        hold(10);

        // Three-cycle glitch on key 2 must be ignored
        step(3'b011); hold(2);
        step(3'b111);
        hold(10);
        chk("glitch_k2", press_cnt[2], 0);

        // Simultaneous press of keys 0 and 2
        step(3'b010);
        hold(10);
        chk("simultaneous_101", int'(saw_101), 1);
        step(3'b111);
        hold(10);

        // Reset two cycles into qualification with key 0 still held
        base = press_cnt[0];
        step(3'b110);
        repeat (4) @(posedge clk);
        do_reset();
        chk("reset_mid_qual_no_pulse", press_cnt[0] - base, 0);
        hold(12);
        chk("reset_mid_qual_press", press_cnt[0] - base, 1);
        step(3'b111);
        hold(10);

        // Randomised patterns with varying hold lengths
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom));
            hold($urandom_range(0, 6));
        end
        step(3'b111);
        hold(12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Upstream conditioning stage for the board push-buttons that drive the switch/LED operand adder. Each raw active-low key is synchronized to `clk`, debounced by a per-key stability counter, and presented downstream as a clean active-low level plus single-cycle press and release pulses. The adder stage consumes `key_db_n` (or `key_press`) in place of the raw `KEY[2:0]` pins, so bounce can no longer cause multiple operand captures.

## Interface
- `N_KEYS`, default 3: number of independent key channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz). Legal range is ≥ 2; simulation uses 4.
- `clk`  in  1: system clock; all state is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `key_raw_n`  in  N_KEYS: raw push-button pins, active-low, asynchronous to `clk`.
- `key_db_n`  out  N_KEYS: debounced level, active-low (0 = pressed).
- `key_press`  out  N_KEYS: one-cycle high pulse on each accepted press.
- `key_release`  out  N_KEYS: one-cycle high pulse on each accepted release.

## Operation
- Each channel runs independently and identically. Channels have no cross-coupling; simultaneous presses yield simultaneous pulses, and the downstream stage applies priority.
- **Synchronizer:** two flops per key; output `s`. Both flops reset to 1 (released).
- **FSM states per channel:**
  - `RELEASED`: if `s`=0, go to `PRESS_WAIT` with count=1.
  - `PRESS_WAIT`: if `s`=1, go back to `RELEASED` with count cleared and no pulse. Otherwise count++. When the count reaches `DEBOUNCE_CYCLES`, go to `PRESSED`, set `key_db_n`=0, and assert `key_press` for one cycle.
  - `PRESSED`: if `s`=1, go to `RELEASE_WAIT` with count=1.
  - `RELEASE_WAIT`: the mirror of `PRESS_WAIT`. An `s`=0 sample returns to `PRESSED` with no pulse. Reaching the limit goes to `RELEASED`, sets `key_db_n`=1, and asserts `key_release`.
- **Counter:**
  - Width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates only by state exit, never wraps, and is cleared in the stable states.
  - Each counted edge is one synchronized sample, so the count equals the number of consecutive stable samples.
- **Output registration:** `key_db_n`, `key_press` and `key_release` are registered. `key_press` and `key_release` are never both high on one channel. A held key produces exactly one press pulse, with no auto-repeat.
- **Reset values:** all states `RELEASED`; counters 0; `key_db_n` all 1; `key_press` and `key_release` all 0.
- **Reset mid-operation:** any in-progress wait is abandoned immediately and no pulse is emitted. After `rst` deasserts with the key held low, the channel performs a full press qualification and emits one `key_press`.

## Timing
- **Press latency:** let raw be low and stable from before edge E0. `s` is low after E1, and samples at E2..E(D+1) are counted (D = `DEBOUNCE_CYCLES`). Therefore:
  - `key_db_n` falls and `key_press` is high in the cycle following E(D+1).
  - `key_press` deasserts after E(D+2).
- **Release latency:** identical in structure, producing `key_release`.
- **Glitch rejection:** any opposite sample before the count completes restarts qualification in full. A bounce train is accepted only after its last transition plus D+1 edges.
- **Minimum accepted pulse width:** D consecutive synchronized samples. Anything shorter produces no output change.

## Structure
- **Shared package `key_pkg`:**
  - `key_state_t` enum: `RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`.
  - Constant `KEY_IDLE_LEVEL = 1'b1`.
  - Default debounce constants: `DEBOUNCE_HW = 1_000_000`, `DEBOUNCE_SIM = 4`.
- **Sub-module:** one sub-module, `debounce_channel`, which contains the synchronizer, counter, FSM and three outputs for a single key. `key_debouncer` instantiates it `N_KEYS` times in a generate loop.

## Test plan
All scenarios use D=4.
- **Reset:** assert `rst` asynchronously mid-cycle. Outputs go immediately to `key_db_n`=3'b111, `key_press`=0, `key_release`=0.
- **Clean press:** `key_raw_n[0]` goes 1→0 before E0 and holds. `key_press[0]`=1 for exactly the cycle after E5 and `key_db_n[0]`=0 from then on. `key_press[1]` and `key_press[2]` stay 0.
- **Bounce:** `key_raw_n[1]` toggles 0,1,0,1 on successive cycles, then holds 0. Exactly one `key_press[1]` occurs, 5 edges after the final 1→0 reaches the pin. A 3-cycle low glitch produces no pulse.
- **Release:** with key 0 held for 20 cycles, release it. `key_release[0]` pulses once 5 edges after the release, and `key_db_n[0]` returns to 1. No extra press pulse occurs during the hold.
- **Simultaneous:** keys 0 and 2 are pressed on the same edge. `key_press`=3'b101 in a single cycle.
- **Reset mid-qualification:** pulse `rst` 2 cycles into `PRESS_WAIT` while the key stays low. No pulse during reset; one `key_press` occurs 5 edges after the first post-reset sampling edge.
